// File: rtl/led_pio_write_arbiter.sv
// Round-robin arbiter that shares the 10-bit LED PIO Avalon-MM slave between NUM_REQ requesters.
// Grant to write is 1 cycle and write to ack is 1 cycle; HOLD_CYCLES idle cycles follow each ack.
// Requests held during WRITE/ACK/hold stall until the next IDLE evaluation; ack is a one-cycle pulse.
module led_pio_write_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 0,
  parameter int HOLD_W      = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [10*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  busy,
  output logic [9:0]            led_state,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   grant_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [9:0]         pat_q;
  logic [9:0]         led_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               busy_q;
  logic               cs_q;
  logic               write_n_q;
  logic [31:0]        wdata_q;

  logic [9:0]         data_arr [NUM_REQ];
  logic [PTR_W-1:0]   grant_d;
  logic               grant_vld;
  logic [PTR_W:0]     sum_c;
  logic [PTR_W-1:0]   next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_arr[g] = req_data[10*g +: 10];
  end

  // Scan downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    grant_d   = '0;
    grant_vld = 1'b0;
    sum_c     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_c = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (sum_c >= (PTR_W+1)'(NUM_REQ)) begin
        sum_c = sum_c - (PTR_W+1)'(NUM_REQ);
      end
      if (req[sum_c[PTR_W-1:0]]) begin
        grant_d   = sum_c[PTR_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      hold_cnt_q <= '0;
      pat_q      <= '0;
      led_q      <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      cs_q       <= 1'b0;
      write_n_q  <= 1'b1;
      wdata_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            busy_q     <= (hold_cnt_q != HOLD_W'(1));
          end else if (grant_vld) begin
            grant_q   <= grant_d;
            pat_q     <= data_arr[grant_d];
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            wdata_q   <= {22'b0, data_arr[grant_d]};
            busy_q    <= 1'b1;
            state_q   <= WRITE;
          end else begin
            busy_q <= 1'b0;
          end
        end
        // Outputs are registered, so the ACK-cycle values are loaded on this edge.
        WRITE: begin
          cs_q      <= 1'b0;
          write_n_q <= 1'b1;
          led_q     <= pat_q;
          ack_q     <= NUM_REQ'(1) << grant_q;
          rr_ptr_q  <= next_ptr;
          busy_q    <= 1'b1;
          state_q   <= ACK;
        end
        ACK: begin
          hold_cnt_q <= HOLD_W'(HOLD_CYCLES);
          busy_q     <= (HOLD_CYCLES != 0);
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack            = ack_q;
  assign busy           = busy_q;
  assign led_state      = led_q;
  assign pio_address    = 2'd0;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = write_n_q;
  assign pio_writedata  = wdata_q;

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// Directed bench for led_pio_write_arbiter: a HOLD_CYCLES=0 and a HOLD_CYCLES=5 instance share the inputs.
module tb_led_pio_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [19:0] req_data = 20'h0;

  logic [1:0]  ack0, ack5;
  logic        busy0, busy5;
  logic [9:0]  led0, led5;
  logic [1:0]  addr0, addr5;
  logic        cs0, cs5;
  logic        wn0, wn5;
  logic [31:0] wd0, wd5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pio_write_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(0), .HOLD_W(24)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .ack(ack0), .busy(busy0), .led_state(led0), .pio_address(addr0),
    .pio_chipselect(cs0), .pio_write_n(wn0), .pio_writedata(wd0)
  );

  led_pio_write_arbiter #(.NUM_REQ(2), .HOLD_CYCLES(5), .HOLD_W(24)) dut5 (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
    .ack(ack5), .busy(busy5), .led_state(led5), .pio_address(addr5),
    .pio_chipselect(cs5), .pio_write_n(wn5), .pio_writedata(wd5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    req      = 2'b11;
    req_data = {10'h3C3, 10'h0AA};
    repeat (3) tick();
    checks++; if (cs0 !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", cs0); end
    checks++; if (wn0 !== 1'b1) begin errors++; $display("FAIL reset_write_n got %b want 1", wn0); end
    checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", ack0); end
    checks++; if (led0 !== 10'h0) begin errors++; $display("FAIL reset_led got %h want 000", led0); end
    checks++; if (wd0 !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", wd0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (addr0 !== 2'b00) begin errors++; $display("FAIL reset_addr got %b want 00", addr0); end
    checks++; if (cs5 !== 1'b0) begin errors++; $display("FAIL reset_cs5 got %b want 0", cs5); end
    reset_n = 1'b1;
    tick();
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL reset_first_cs got %b want 1", cs0); end
    checks++; if (wd0 !== 32'h0AA) begin errors++; $display("FAIL reset_first_req0 got %h want 000000aa", wd0); end
    tick();
    checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL reset_first_ack got %b want 01", ack0); end
    req = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_single();
    req      = 2'b01;
    req_data = {10'h000, 10'h155};
    tick();
    checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL single_cs got %b want 1", cs0); end
    checks++; if (wn0 !== 1'b0) begin errors++; $display("FAIL single_write_n got %b want 0", wn0); end
    checks++; if (wd0 !== 32'h155) begin errors++; $display("FAIL single_wdata got %h want 00000155", wd0); end
    checks++; if (addr0 !== 2'b00) begin errors++; $display("FAIL single_addr got %b want 00", addr0); end
    checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL single_early_ack got %b want 00", ack0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy0); end
    req = 2'b00;
    tick();
    checks++; if (ack0 !== 2'b01) begin errors++; $display("FAIL single_ack got %b want 01", ack0); end
    checks++; if (led0 !== 10'h155) begin errors++; $display("FAIL single_led got %h want 155", led0); end
    checks++; if (cs0 !== 1'b0 || wn0 !== 1'b1) begin errors++; $display("FAIL single_strobe_idle got cs=%b wn=%b want cs=0 wn=1", cs0, wn0); end
    tick();
    checks++; if (ack0 !== 2'b00) begin errors++; $display("FAIL single_ack_pulse got %b want 00", ack0); end
    req      = 2'b10;
    req_data = {10'h2AA, 10'h155};
    tick();
    checks++; if (wd0 !== 32'h2AA) begin errors++; $display("FAIL single1_wdata got %h want 000002aa", wd0); end
    req = 2'b00;
    tick();
    checks++; if (ack0 !== 2'b10) begin errors++; $display("FAIL single1_ack got %b want 10", ack0); end
    tick();
  endtask

  task automatic test_fairness();
    logic [9:0] exp_dat [4];
    logic [1:0] exp_ack [4];
    exp_dat[0] = 10'h001; exp_dat[1] = 10'h200; exp_dat[2] = 10'h001; exp_dat[3] = 10'h200;
    exp_ack[0] = 2'b01;   exp_ack[1] = 2'b10;   exp_ack[2] = 2'b01;   exp_ack[3] = 2'b10;
    req      = 2'b11;
    req_data = {10'h200, 10'h001};
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (cs0 !== 1'b1 || wd0 !== {22'b0, exp_dat[i]}) begin
        errors++; $display("FAIL fair_write%0d got cs=%b data=%h want cs=1 data=%h", i, cs0, wd0, exp_dat[i]);
      end
      tick();
      checks++; if (ack0 !== exp_ack[i] || led0 !== exp_dat[i]) begin
        errors++; $display("FAIL fair_ack%0d got ack=%b led=%h want ack=%b led=%h", i, ack0, led0, exp_ack[i], exp_dat[i]);
      end
      tick();
      checks++; if (cs0 !== 1'b0) begin errors++; $display("FAIL fair_idle%0d got cs=%b want 0", i, cs0); end
    end
    req = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_hold();
    int n;
    for (n = 0; n < 40 && busy5 !== 1'b0; n++) tick();
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL hold_wait_idle got busy=%b want 0", busy5); end
    req      = 2'b01;
    req_data = {10'h000, 10'h0F0};
    for (n = 0; n < 20 && cs5 !== 1'b1; n++) tick();
    checks++; if (cs5 !== 1'b1) begin errors++; $display("FAIL hold_first_write got cs=%b want 1", cs5); end
    checks++; if (busy5 !== 1'b1) begin errors++; $display("FAIL hold_busy_c0 got %b want 1", busy5); end
    tick();
    checks++; if (ack5 !== 2'b01 || led5 !== 10'h0F0) begin
      errors++; $display("FAIL hold_ack got ack=%b led=%h want ack=01 led=0f0", ack5, led5);
    end
    for (int c = 2; c <= 6; c++) begin
      tick();
      checks++; if (busy5 !== 1'b1 || cs5 !== 1'b0) begin
        errors++; $display("FAIL hold_gap%0d got busy=%b cs=%b want busy=1 cs=0", c, busy5, cs5);
      end
    end
    tick();
    checks++; if (cs5 !== 1'b0) begin errors++; $display("FAIL hold_gap7 got cs=%b want 0", cs5); end
    tick();
    checks++; if (cs5 !== 1'b1) begin errors++; $display("FAIL hold_period8 got cs=%b want 1", cs5); end
  endtask

  task automatic test_withdrawn();
    req = 2'b00;
    tick();
    checks++; if (ack5 !== 2'b01) begin errors++; $display("FAIL wd_prior_ack got %b want 01", ack5); end
    tick();
    req      = 2'b10;
    req_data = {10'h3FF, 10'h0F0};
    tick();
    req = 2'b00;
    for (int c = 0; c < 10; c++) begin
      checks++; if (cs5 !== 1'b0 || ack5 !== 2'b00) begin
        errors++; $display("FAIL wd_quiet%0d got cs=%b ack=%b want cs=0 ack=00", c, cs5, ack5);
      end
      tick();
    end
    checks++; if (led5 !== 10'h0F0) begin errors++; $display("FAIL wd_led got %h want 0f0", led5); end
  endtask

  task automatic test_reset_mid();
    req = 2'b00;
    repeat (3) tick();
    req      = 2'b01;
    req_data = {10'h333, 10'h044};
    tick();
    req = 2'b00;
    repeat (2) tick();
    req = 2'b10;
    tick();
    checks++; if (cs0 !== 1'b1 || wd0 !== 32'h333) begin
      errors++; $display("FAIL mid_write got cs=%b data=%h want cs=1 data=00000333", cs0, wd0);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (cs0 !== 1'b0 || wn0 !== 1'b1) begin
      errors++; $display("FAIL mid_async_strobe got cs=%b wn=%b want cs=0 wn=1", cs0, wn0);
    end
    req = 2'b00;
    repeat (2) tick();
    checks++; if (ack0 !== 2'b00 || led0 !== 10'h0) begin
      errors++; $display("FAIL mid_no_ack got ack=%b led=%h want ack=00 led=000", ack0, led0);
    end
    reset_n  = 1'b1;
    req      = 2'b11;
    req_data = {10'h322, 10'h011};
    tick();
    checks++; if (cs0 !== 1'b1 || wd0 !== 32'h011) begin
      errors++; $display("FAIL mid_rr_reset got cs=%b data=%h want cs=1 data=00000011", cs0, wd0);
    end
    req = 2'b00;
    tick();
    checks++; if (ack0 !== 2'b01 || led0 !== 10'h011) begin
      errors++; $display("FAIL mid_after_ack got ack=%b led=%h want ack=01 led=011", ack0, led0);
    end
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_hold();
    test_withdrawn();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
